// File: rtl/alu_issue_stage.sv
// alu_issue_stage: two-stage RV32I decode/issue stage that feeds ALU select, shift and operand inputs
module alu_issue_stage #(
    parameter int XLEN       = 32,
    parameter int SEL_SIZE   = 4,
    parameter int SHIFT_SIZE = 5
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [31:0]           in_instr,
    input  logic [XLEN-1:0]       in_pc,
    output logic [4:0]            rf_raddr1,
    output logic [4:0]            rf_raddr2,
    input  logic [XLEN-1:0]       rf_rdata1,
    input  logic [XLEN-1:0]       rf_rdata2,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  alu_enable,
    output logic [SEL_SIZE-1:0]   alu_sel,
    output logic [SHIFT_SIZE:0]   alu_shift_amt,
    output logic [XLEN-1:0]       alu_a,
    output logic [XLEN-1:0]       alu_b,
    output logic [4:0]            rd,
    output logic                  rd_we,
    output logic                  illegal
);
    localparam int SW = SHIFT_SIZE + 1;
    localparam logic [6:0] OPC_OP    = 7'b0110011;
    localparam logic [6:0] OPC_IMM   = 7'b0010011;
    localparam logic [6:0] OPC_LUI   = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC = 7'b0010111;
    localparam logic [SEL_SIZE-1:0] SEL_ADD   = SEL_SIZE'(0);
    localparam logic [SEL_SIZE-1:0] SEL_SUB   = SEL_SIZE'(1);
    localparam logic [SEL_SIZE-1:0] SEL_SLT   = SEL_SIZE'(2);
    localparam logic [SEL_SIZE-1:0] SEL_SLTU  = SEL_SIZE'(3);
    localparam logic [SEL_SIZE-1:0] SEL_AND   = SEL_SIZE'(4);
    localparam logic [SEL_SIZE-1:0] SEL_OR    = SEL_SIZE'(5);
    localparam logic [SEL_SIZE-1:0] SEL_XOR   = SEL_SIZE'(6);
    localparam logic [SEL_SIZE-1:0] SEL_SLL   = SEL_SIZE'(7);
    localparam logic [SEL_SIZE-1:0] SEL_SRL   = SEL_SIZE'(8);
    localparam logic [SEL_SIZE-1:0] SEL_SRA   = SEL_SIZE'(9);
    localparam logic [SEL_SIZE-1:0] SEL_LUI   = SEL_SIZE'(10);
    localparam logic [SEL_SIZE-1:0] SEL_AUIPC = SEL_SIZE'(11);

    logic                s1_valid, s1_fresh, s2_valid, s1_adv;
    logic [31:0]         s1_instr;
    logic [XLEN-1:0]     s1_pc, s1_rs1, s1_rs2, rs1, rs2;
    logic [2:0]          f3;
    logic [6:0]          f7;
    logic                f7_zero, f7_alt, is_shift;
    logic                d_legal;
    logic [SEL_SIZE-1:0] base_sel, d_sel;
    logic [SW-1:0]       d_sh;
    logic [XLEN-1:0]     d_a, d_b;

    assign rf_raddr1 = in_instr[19:15];
    assign rf_raddr2 = in_instr[24:20];
    assign out_valid = s2_valid;
    assign s1_adv    = !s2_valid | out_ready;
    assign in_ready  = flush | !s1_valid | s1_adv;
    // register data is only valid in the first S1 cycle; afterwards the captured copy is used
    assign rs1       = s1_fresh ? rf_rdata1 : s1_rs1;
    assign rs2       = s1_fresh ? rf_rdata2 : s1_rs2;
    assign f3        = s1_instr[14:12];
    assign f7        = s1_instr[31:25];
    assign f7_zero   = f7 == 7'b0000000;
    assign f7_alt    = f7 == 7'b0100000;
    assign is_shift  = f3 == 3'b001 || f3 == 3'b101;

    // S1: capture instruction and pc on accept, snapshot register data at the end of the first S1 cycle
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_valid <= 1'b0;
            s1_fresh <= 1'b0;
            s1_instr <= '0;
            s1_pc    <= '0;
            s1_rs1   <= '0;
            s1_rs2   <= '0;
        end else begin
            if (s1_fresh) begin
                s1_rs1 <= rf_rdata1;
                s1_rs2 <= rf_rdata2;
            end
            s1_fresh <= in_valid & in_ready & !flush;
            if (flush) begin
                s1_valid <= 1'b0;
            end else if (in_ready) begin
                s1_valid <= in_valid;
                if (in_valid) begin
                    s1_instr <= in_instr;
                    s1_pc    <= in_pc;
                end
            end
        end
    end

    // funct3 to base ALU select
    always_comb begin
        base_sel = SEL_ADD;
        case (f3)
            3'b001:  base_sel = SEL_SLL;
            3'b010:  base_sel = SEL_SLT;
            3'b011:  base_sel = SEL_SLTU;
            3'b100:  base_sel = SEL_XOR;
            3'b101:  base_sel = SEL_SRL;
            3'b110:  base_sel = SEL_OR;
            3'b111:  base_sel = SEL_AND;
            default: base_sel = SEL_ADD;
        endcase
    end

    // decode S1 into ALU controls and operands; illegal slots carry all-zero controls
    always_comb begin
        d_legal = 1'b0;
        d_sel   = SEL_ADD;
        d_sh    = '0;
        d_a     = '0;
        d_b     = '0;
        case (s1_instr[6:0])
            OPC_OP: begin
                d_legal = f7_zero | (f7_alt & (f3 == 3'b000 || f3 == 3'b101));
                d_sel   = f7_alt ? ((f3 == 3'b000) ? SEL_SUB : SEL_SRA) : base_sel;
                d_a     = (f7_alt && f3 == 3'b000) ? rs2 : rs1;
                d_b     = (f7_alt && f3 == 3'b000) ? rs1 : rs2;
                d_sh    = is_shift ? SW'(rs2[SHIFT_SIZE-1:0]) : '0;
            end
            OPC_IMM: begin
                d_legal = (f3 == 3'b001) ? f7_zero : (f3 == 3'b101) ? (f7_zero | f7_alt) : 1'b1;
                d_sel   = (f3 == 3'b101 && f7_alt) ? SEL_SRA : base_sel;
                d_a     = rs1;
                d_b     = {{(XLEN-12){s1_instr[31]}}, s1_instr[31:20]};
                d_sh    = is_shift ? SW'(s1_instr[24:20]) : '0;
            end
            OPC_LUI: begin
                d_legal = 1'b1;
                d_sel   = SEL_LUI;
                d_a     = {{(XLEN-20){1'b0}}, s1_instr[31:12]};
            end
            OPC_AUIPC: begin
                d_legal = 1'b1;
                d_sel   = SEL_AUIPC;
                d_a     = {{(XLEN-20){1'b0}}, s1_instr[31:12]};
                d_b     = s1_pc;
            end
            default: d_legal = 1'b0;
        endcase
        if (!d_legal) begin
            d_sel = SEL_ADD;
            d_sh  = '0;
            d_a   = '0;
            d_b   = '0;
        end
    end

    // S2: output register loads only when S1 advances; flush or an empty load clears the slot
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s2_valid      <= 1'b0;
            alu_enable    <= 1'b0;
            alu_sel       <= '0;
            alu_shift_amt <= '0;
            alu_a         <= '0;
            alu_b         <= '0;
            rd            <= '0;
            rd_we         <= 1'b0;
            illegal       <= 1'b0;
        end else if (flush) begin
            s2_valid   <= 1'b0;
            alu_enable <= 1'b0;
        end else if (s1_adv) begin
            s2_valid   <= s1_valid;
            alu_enable <= s1_valid & d_legal;
            if (s1_valid) begin
                alu_sel       <= d_sel;
                alu_shift_amt <= d_sh;
                alu_a         <= d_a;
                alu_b         <= d_b;
                rd            <= s1_instr[11:7];
                rd_we         <= d_legal & (s1_instr[11:7] != 5'd0);
                illegal       <= !d_legal;
            end
        end
    end
endmodule

// File: tb/tb_alu_issue_stage.sv
// tb_alu_issue_stage: directed and randomized checks of alu_issue_stage against a queue-based reference
module tb_alu_issue_stage;
    typedef struct packed {
        logic        ill;
        logic        en;
        logic        we;
        logic [3:0]  sel;
        logic [5:0]  sh;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  rd;
    } exp_t;

    localparam logic [3:0] SEL_OF_F3 [8] = '{4'd0, 4'd7, 4'd2, 4'd3, 4'd6, 4'd8, 4'd5, 4'd4};

    logic        clk = 1'b0, reset_n = 1'b0, flush = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
    logic [31:0] in_instr = '0, in_pc = '0, rf_rdata1 = '0, rf_rdata2 = '0;
    logic        in_ready, out_valid, alu_enable, rd_we, illegal;
    logic [4:0]  rf_raddr1, rf_raddr2, rd;
    logic [3:0]  alu_sel;
    logic [5:0]  alu_shift_amt;
    logic [31:0] alu_a, alu_b;
    logic [31:0] regs [32];
    exp_t        obs;
    int          checks = 0, errors = 0;

    alu_issue_stage dut (
        .clk(clk), .reset_n(reset_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
        .rf_raddr1(rf_raddr1), .rf_raddr2(rf_raddr2), .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2),
        .out_valid(out_valid), .out_ready(out_ready), .alu_enable(alu_enable), .alu_sel(alu_sel),
        .alu_shift_amt(alu_shift_amt), .alu_a(alu_a), .alu_b(alu_b), .rd(rd), .rd_we(rd_we),
        .illegal(illegal)
    );

    assign obs = {illegal, alu_enable, rd_we, alu_sel, alu_shift_amt, alu_a, alu_b, rd};

    always #5 clk = ~clk;

    // synchronous-read register file: data appears the cycle after the address
    always @(posedge clk) begin
        rf_rdata1 <= regs[rf_raddr1];
        rf_rdata2 <= regs[rf_raddr2];
    end

    function automatic exp_t ref_model(input logic [31:0] ins, input logic [31:0] pc,
                                       input logic [31:0] r1, input logic [31:0] r2);
        exp_t e;
        logic ok;
        logic [2:0] f3;
        logic [6:0] f7;
        f3 = ins[14:12];
        f7 = ins[31:25];
        e = '0;
        e.rd = ins[11:7];
        ok = 1'b0;
        case (ins[6:0])
            7'h33: begin
                ok = f7 == 7'h00 || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5));
                e.sel = SEL_OF_F3[f3];
                if (f7 == 7'h20) e.sel = (f3 == 3'd0) ? 4'd1 : 4'd9;
                e.a = (e.sel == 4'd1) ? r2 : r1;
                e.b = (e.sel == 4'd1) ? r1 : r2;
                if (f3 == 3'd1 || f3 == 3'd5) e.sh = {1'b0, r2[4:0]};
            end
            7'h13: begin
                ok = (f3 == 3'd1) ? (f7 == 7'h00) : (f3 == 3'd5) ? (f7 == 7'h00 || f7 == 7'h20) : 1'b1;
                e.sel = SEL_OF_F3[f3];
                if (f3 == 3'd5 && f7 == 7'h20) e.sel = 4'd9;
                e.a = r1;
                e.b = {{20{ins[31]}}, ins[31:20]};
                if (f3 == 3'd1 || f3 == 3'd5) e.sh = {1'b0, ins[24:20]};
            end
            7'h37: begin ok = 1'b1; e.sel = 4'd10; e.a = ins >> 12; end
            7'h17: begin ok = 1'b1; e.sel = 4'd11; e.a = ins >> 12; e.b = pc; end
            default: ok = 1'b0;
        endcase
        if (ok) begin
            e.en = 1'b1;
            e.we = ins[11:7] != 5'd0;
        end else begin
            e.ill = 1'b1;
            e.sel = '0;
            e.sh = '0;
            e.a = '0;
            e.b = '0;
        end
        return e;
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [31:0] w;
        int k, f;
        w = $urandom;
        k = $urandom_range(0, 9);
        f = $urandom_range(0, 3);
        if (k <= 2) w[6:0] = 7'h33;
        else if (k <= 5) w[6:0] = 7'h13;
        else if (k == 6) w[6:0] = 7'h37;
        else if (k == 7) w[6:0] = 7'h17;
        if (f <= 1) w[31:25] = 7'h00;
        else if (f == 2) w[31:25] = 7'h20;
        return w;
    endfunction

    task automatic test_reset();
        repeat (2) @(negedge clk);
        checks++;
        if ({out_valid, obs} !== '0) begin
            errors++;
            $display("FAIL reset_outputs got=%h want=0", {out_valid, obs});
        end
        reset_n = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_in_ready got=%b want=1", in_ready);
        end
    endtask

    task automatic test_decode();
        logic [31:0] ins [10];
        logic [31:0] pcs [10];
        exp_t        ex  [10];
        ins = '{32'h002081B3, 32'h402081B3, 32'h123452B7, 32'h12345297, 32'h40315093,
                32'h0000007F, 32'h00208033, 32'h022081B3, 32'h40209093, 32'h002091B3};
        pcs = '{32'h0, 32'h0, 32'h0, 32'h100, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0};
        ex  = '{'{1'b0, 1'b1, 1'b1, 4'd0,  6'd0, 32'd5,       32'd7,     5'd3},
                '{1'b0, 1'b1, 1'b1, 4'd1,  6'd0, 32'd7,       32'd5,     5'd3},
                '{1'b0, 1'b1, 1'b1, 4'd10, 6'd0, 32'h12345,   32'h0,     5'd5},
                '{1'b0, 1'b1, 1'b1, 4'd11, 6'd0, 32'h12345,   32'h100,   5'd5},
                '{1'b0, 1'b1, 1'b1, 4'd9,  6'd3, 32'd7,       32'h403,   5'd1},
                '{1'b1, 1'b0, 1'b0, 4'd0,  6'd0, 32'd0,       32'd0,     5'd0},
                '{1'b0, 1'b1, 1'b0, 4'd0,  6'd0, 32'd5,       32'd7,     5'd0},
                '{1'b1, 1'b0, 1'b0, 4'd0,  6'd0, 32'd0,       32'd0,     5'd3},
                '{1'b1, 1'b0, 1'b0, 4'd0,  6'd0, 32'd0,       32'd0,     5'd1},
                '{1'b0, 1'b1, 1'b1, 4'd7,  6'd7, 32'd5,       32'd7,     5'd3}};
        for (int i = 0; i < 32; i++) regs[i] = '0;
        regs[1] = 32'd5;
        regs[2] = 32'd7;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_instr = ins[i];
            in_pc = pcs[i];
            out_ready = 1'b1;
            @(negedge clk);
            in_valid = 1'b0;
            checks++;
            if (out_valid !== 1'b0) begin
                errors++;
                $display("FAIL latency_early[%0d] out_valid=%b want=0", i, out_valid);
            end
            @(negedge clk);
            checks++;
            if (out_valid !== 1'b1) begin
                errors++;
                $display("FAIL latency_t2[%0d] out_valid=%b want=1", i, out_valid);
            end
            checks++;
            if (obs !== ex[i]) begin
                errors++;
                $display("FAIL decode[%0d] instr=%h got=%h want=%h", i, ins[i], obs, ex[i]);
            end
        end
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || alu_enable !== 1'b0) begin
            errors++;
            $display("FAIL drain_empty out_valid=%b alu_enable=%b want=0,0", out_valid, alu_enable);
        end
    endtask

    task automatic test_back_to_back_stall();
        logic [31:0] ins [3];
        logic [31:0] got [$];
        int idx, acc_early;
        logic acc;
        idx = 0;
        acc_early = 0;
        acc = 1'b0;
        for (int k = 0; k < 3; k++) ins[k] = 32'h00008213 | ((k + 1) << 20);
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (acc) idx++;
            in_valid = idx < 3;
            in_instr = (idx < 3) ? ins[idx] : 32'h0;
            out_ready = c >= 5;
            #1;
            acc = in_valid & in_ready;
            if (acc && c < 5) acc_early++;
            if (c >= 2 && c <= 4) begin
                checks++;
                if (in_ready !== 1'b0 || out_valid !== 1'b1 || alu_b !== 32'd1) begin
                    errors++;
                    $display("FAIL stall_hold c=%0d in_ready=%b out_valid=%b b=%h want=0,1,1", c, in_ready, out_valid, alu_b);
                end
            end
            if (out_valid && out_ready) got.push_back(alu_b);
        end
        in_valid = 1'b0;
        checks++;
        if (acc_early != 2) begin
            errors++;
            $display("FAIL stall_accepts got=%0d want=2", acc_early);
        end
        checks++;
        if (got.size() != 3 || got[0] !== 32'd1 || got[1] !== 32'd2 || got[2] !== 32'd3) begin
            errors++;
            $display("FAIL stall_order count=%0d want=3 in order 1,2,3", got.size());
        end
    endtask

    task automatic test_flush();
        @(negedge clk);
        out_ready = 1'b0;
        in_valid = 1'b1;
        in_instr = 32'h00108213;
        @(negedge clk);
        in_instr = 32'h00208213;
        @(negedge clk);
        flush = 1'b1;
        in_instr = 32'h00308213;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL flush_in_ready got=%b want=1", in_ready);
        end
        @(negedge clk);
        flush = 1'b0;
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || alu_enable !== 1'b0) begin
            errors++;
            $display("FAIL flush_clear out_valid=%b alu_enable=%b want=0,0", out_valid, alu_enable);
        end
        out_ready = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL flush_dropped out_valid=%b want=0", out_valid);
        end
    endtask

    task automatic test_async_reset();
        @(negedge clk);
        in_valid = 1'b1;
        in_instr = 32'h002081B3;
        out_ready = 1'b0;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        checks++;
        if ({out_valid, obs} !== '0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL async_reset got=%h in_ready=%b want=0,1", {out_valid, obs}, in_ready);
        end
        @(negedge clk);
        reset_n = 1'b1;
        in_valid = 1'b1;
        in_instr = 32'h123452B7;
        out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b1 || alu_sel !== 4'd10 || alu_a !== 32'h12345) begin
            errors++;
            $display("FAIL reset_first_accept out_valid=%b sel=%0d a=%h want=1,10,12345", out_valid, alu_sel, alu_a);
        end
    endtask

    task automatic test_random();
        exp_t q [$];
        logic exp_ov, exp_ir;
        int n;
        for (int i = 1; i < 32; i++) regs[i] = $urandom;
        regs[0] = '0;
        @(negedge clk);
        flush = 1'b1;
        in_valid = 1'b0;
        @(negedge clk);
        flush = 1'b0;
        exp_ov = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            checks++;
            if (out_valid !== exp_ov) begin
                errors++;
                $display("FAIL rand_out_valid c=%0d got=%b want=%b", c, out_valid, exp_ov);
            end
            checks++;
            if (exp_ov && obs !== q[0]) begin
                errors++;
                $display("FAIL rand_payload c=%0d got=%h want=%h", c, obs, q[0]);
            end else if (!exp_ov && alu_enable !== 1'b0) begin
                errors++;
                $display("FAIL rand_empty_enable c=%0d got=%b want=0", c, alu_enable);
            end
            in_valid = $urandom_range(0, 9) < 7;
            in_instr = rand_instr();
            in_pc = $urandom & 32'hFFFFFFFC;
            out_ready = $urandom_range(0, 3) != 0;
            flush = $urandom_range(0, 39) == 0;
            #1;
            n = q.size();
            exp_ir = flush || n < 2 || (exp_ov && out_ready);
            checks++;
            if (in_ready !== exp_ir) begin
                errors++;
                $display("FAIL rand_in_ready c=%0d got=%b want=%b", c, in_ready, exp_ir);
            end
            if (flush) begin
                q.delete();
                exp_ov = 1'b0;
            end else begin
                if (exp_ov && out_ready) void'(q.pop_front());
                exp_ov = q.size() > 0;
                if (in_valid && in_ready)
                    q.push_back(ref_model(in_instr, in_pc, regs[in_instr[19:15]], regs[in_instr[24:20]]));
            end
        end
        @(negedge clk);
        flush = 1'b0;
        in_valid = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 32; i++) regs[i] = '0;
        test_reset();
        test_decode();
        test_back_to_back_stall();
        test_flush();
        test_async_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
